// File: rtl/hazard_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard controller.
// Forward-select encodings, FSM state type and the select-priority helper.
package hazard_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef enum logic {
    RUN  = 1'b0,
    MULT = 1'b1
  } state_t;

  // The M-stage value is younger than the W-stage value, so M wins.
  function automatic logic [1:0] fwd_pick(input logic hit_m, input logic hit_w);
    if (hit_m)      return FWD_M;
    else if (hit_w) return FWD_W;
    else            return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Forward selects for one E-stage operand bus: the primary destination
// forward and the matching base-writeback (index) forward.
module hazard_ctrl_fwd_sel
  import hazard_pkg::*;
(
  input  logic       match_m,
  input  logic       match_w,
  input  logic       match_m_index,
  input  logic       match_w_index,
  input  logic       reg_write_m,
  input  logic       reg_write_w,
  input  logic       write_back_m,
  input  logic       write_back_w,
  output logic [1:0] fwd,
  output logic [1:0] fwd_index
);

  assign fwd       = fwd_pick(match_m & reg_write_m, match_w & reg_write_w);
  assign fwd_index = fwd_pick(match_m_index & write_back_m,
                              match_w_index & write_back_w);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the F/D/E/M/W datapath: operand
// forwarding, stall/flush generation, multi-cycle multiply FSM, stall counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MUL_CYCLES = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Match_1E_M,
  input  logic             Match_1E_W,
  input  logic             Match_2E_M,
  input  logic             Match_2E_W,
  input  logic             Match_3E_M,
  input  logic             Match_3E_W,
  input  logic             Match_1E_M_Index,
  input  logic             Match_1E_W_Index,
  input  logic             Match_2E_M_Index,
  input  logic             Match_2E_W_Index,
  input  logic             Match_3E_M_Index,
  input  logic             Match_3E_W_Index,
  input  logic             Match_12D_E,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             WriteBackM,
  input  logic             WriteBackW,
  input  logic             MemtoRegE,
  input  logic             RegWriteE,
  input  logic             PCSrcD,
  input  logic             PCSrcE,
  input  logic             PCSrcM,
  input  logic             PCSrcW,
  input  logic             BranchMissed,
  input  logic             MulOpE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [1:0]       ForwardCE,
  output logic [1:0]       ForwardAEIndex,
  output logic [1:0]       ForwardBEIndex,
  output logic [1:0]       ForwardCEIndex,
  output logic             MulBusy,
  output logic [CNT_W-1:0] StallCount
);

  // The first multiply cycle is spent in RUN, so MULT covers the rest.
  localparam logic [3:0] MUL_LOAD  = 4'(MUL_CYCLES - 1);
  localparam bit         MUL_MULTI = (MUL_CYCLES > 1);

  state_t     state;
  logic [3:0] cnt;
  logic       busy;
  logic       ldrstall;
  logic       pc_wr_pend;

  hazard_ctrl_fwd_sel u_fwd_a (
    .match_m       (Match_1E_M),
    .match_w       (Match_1E_W),
    .match_m_index (Match_1E_M_Index),
    .match_w_index (Match_1E_W_Index),
    .reg_write_m   (RegWriteM),
    .reg_write_w   (RegWriteW),
    .write_back_m  (WriteBackM),
    .write_back_w  (WriteBackW),
    .fwd           (ForwardAE),
    .fwd_index     (ForwardAEIndex)
  );

  hazard_ctrl_fwd_sel u_fwd_b (
    .match_m       (Match_2E_M),
    .match_w       (Match_2E_W),
    .match_m_index (Match_2E_M_Index),
    .match_w_index (Match_2E_W_Index),
    .reg_write_m   (RegWriteM),
    .reg_write_w   (RegWriteW),
    .write_back_m  (WriteBackM),
    .write_back_w  (WriteBackW),
    .fwd           (ForwardBE),
    .fwd_index     (ForwardBEIndex)
  );

  hazard_ctrl_fwd_sel u_fwd_c (
    .match_m       (Match_3E_M),
    .match_w       (Match_3E_W),
    .match_m_index (Match_3E_M_Index),
    .match_w_index (Match_3E_W_Index),
    .reg_write_m   (RegWriteM),
    .reg_write_w   (RegWriteW),
    .write_back_m  (WriteBackM),
    .write_back_w  (WriteBackW),
    .fwd           (ForwardCE),
    .fwd_index     (ForwardCEIndex)
  );

  assign ldrstall   = Match_12D_E & MemtoRegE & RegWriteE;
  assign pc_wr_pend = PCSrcD | PCSrcE | PCSrcM;
  assign busy       = (state == MULT);

  // While E is held the D-stage branch stays put, so its flush waits for RUN.
  assign StallF  = ldrstall | pc_wr_pend | busy;
  assign StallD  = ldrstall | busy;
  assign StallE  = busy;
  assign FlushM  = busy;
  assign FlushD  = (pc_wr_pend | PCSrcW | BranchMissed) & ~busy;
  assign FlushE  = ldrstall & ~busy;
  assign MulBusy = busy;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (MulOpE && MUL_MULTI) begin
            state <= MULT;
            cnt   <= MUL_LOAD;
          end
        end
        MULT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      StallCount <= '0;
    end else if (StallF && (StallCount != {CNT_W{1'b1}})) begin
      StallCount <= StallCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MUL_CYCLES=3, CNT_W=4 so
// counter saturation is reachable in a short run).
module tb_hazard_ctrl;

  localparam int MUL_CYCLES = 3;
  localparam int CNT_W      = 4;

  logic clk = 1'b0;
  logic reset;
  logic Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_3E_M, Match_3E_W;
  logic Match_1E_M_Index, Match_1E_W_Index, Match_2E_M_Index, Match_2E_W_Index;
  logic Match_3E_M_Index, Match_3E_W_Index;
  logic Match_12D_E, RegWriteM, RegWriteW, WriteBackM, WriteBackW;
  logic MemtoRegE, RegWriteE, PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchMissed, MulOpE;
  logic StallF, StallD, StallE, FlushD, FlushE, FlushM, MulBusy;
  logic [1:0] ForwardAE, ForwardBE, ForwardCE;
  logic [1:0] ForwardAEIndex, ForwardBEIndex, ForwardCEIndex;
  logic [CNT_W-1:0] StallCount;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MUL_CYCLES(MUL_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .Match_1E_M(Match_1E_M), .Match_1E_W(Match_1E_W),
    .Match_2E_M(Match_2E_M), .Match_2E_W(Match_2E_W),
    .Match_3E_M(Match_3E_M), .Match_3E_W(Match_3E_W),
    .Match_1E_M_Index(Match_1E_M_Index), .Match_1E_W_Index(Match_1E_W_Index),
    .Match_2E_M_Index(Match_2E_M_Index), .Match_2E_W_Index(Match_2E_W_Index),
    .Match_3E_M_Index(Match_3E_M_Index), .Match_3E_W_Index(Match_3E_W_Index),
    .Match_12D_E(Match_12D_E), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .WriteBackM(WriteBackM), .WriteBackW(WriteBackW),
    .MemtoRegE(MemtoRegE), .RegWriteE(RegWriteE),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
    .BranchMissed(BranchMissed), .MulOpE(MulOpE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ForwardCE(ForwardCE),
    .ForwardAEIndex(ForwardAEIndex), .ForwardBEIndex(ForwardBEIndex),
    .ForwardCEIndex(ForwardCEIndex),
    .MulBusy(MulBusy), .StallCount(StallCount)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Packs {StallF,StallD,StallE,FlushD,FlushE,FlushM,MulBusy} for compact checks.
  function automatic logic [15:0] ctl();
    return {9'd0, StallF, StallD, StallE, FlushD, FlushE, FlushM, MulBusy};
  endfunction

  task automatic clear_inputs();
    {Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_3E_M, Match_3E_W} = '0;
    {Match_1E_M_Index, Match_1E_W_Index, Match_2E_M_Index} = '0;
    {Match_2E_W_Index, Match_3E_M_Index, Match_3E_W_Index} = '0;
    {Match_12D_E, RegWriteM, RegWriteW, WriteBackM, WriteBackW} = '0;
    {MemtoRegE, RegWriteE, PCSrcD, PCSrcE, PCSrcM, PCSrcW} = '0;
    {BranchMissed, MulOpE} = '0;
  endtask

  // Advance one clock; inputs are changed 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    settle();
    check("reset_ctl", ctl(), 16'h0000);
    check("reset_cnt", 16'(StallCount), 16'd0);
    check("reset_fwd", {4'd0, ForwardAE, ForwardBE, ForwardCE,
                        ForwardAEIndex, ForwardBEIndex, ForwardCEIndex}, 16'd0);

    // Forwarding
    Match_1E_M = 1; RegWriteM = 1; Match_1E_W = 1; RegWriteW = 1;
    settle();
    check("fwd_a_m_prio", 16'(ForwardAE), 16'h2);
    check("fwd_b_idle", 16'(ForwardBE), 16'h0);
    RegWriteM = 0;
    settle();
    check("fwd_a_w", 16'(ForwardAE), 16'h1);
    Match_2E_W_Index = 1; WriteBackW = 1;
    settle();
    check("fwd_b_idx_w", 16'(ForwardBEIndex), 16'h1);
    check("fwd_b_prim", 16'(ForwardBE), 16'h0);
    Match_3E_M = 1;
    settle();
    check("fwd_c_no_wr", 16'(ForwardCE), 16'h0);
    Match_3E_M_Index = 1; Match_3E_W_Index = 1; WriteBackM = 1;
    settle();
    check("fwd_c_idx_m", 16'(ForwardCEIndex), 16'h2);
    check("fwd_a_idx", 16'(ForwardAEIndex), 16'h0);
    check("fwd_noctl", ctl(), 16'h0000);

    // Load-use: StallF, StallD, FlushE
    clear_inputs();
    Match_12D_E = 1; MemtoRegE = 1; RegWriteE = 1;
    settle();
    check("ldr_ctl", ctl(), 16'b1100100);
    step();
    clear_inputs();
    settle();
    check("ldr_cnt", 16'(StallCount), 16'd1);
    check("ldr_clear", ctl(), 16'h0000);

    // Multiply: first cycle in RUN, then 2 MULT cycles, then back-to-back multiply
    MulOpE = 1;
    settle();
    check("mul_run0", ctl(), 16'h0000);
    for (int i = 0; i < 2; i++) begin
      step();
      settle();
      check($sformatf("mul_busy%0d", i), ctl(), 16'b1110011);
    end
    step();
    settle();
    check("mul_b2b_run", ctl(), 16'h0000);
    for (int i = 0; i < 2; i++) begin
      step();
      settle();
      check($sformatf("mul2_busy%0d", i), ctl(), 16'b1110011);
    end
    step();
    MulOpE = 0;
    settle();
    check("mul_done", ctl(), 16'h0000);
    check("mul_cnt", 16'(StallCount), 16'd5);

    // Branch mispredict during MULT
    MulOpE = 1;
    step();
    BranchMissed = 1;
    settle();
    check("br_busy0_flushd", 16'(FlushD), 16'd0);
    step();
    settle();
    check("br_busy1_ctl", ctl(), 16'b1110011);
    step();
    MulOpE = 0;
    settle();
    check("br_run_ctl", ctl(), 16'b0001000);
    check("br_cnt", 16'(StallCount), 16'd7);

    // PC write walks D -> E -> M -> W
    clear_inputs();
    PCSrcD = 1;
    settle();
    check("pc_d", ctl(), 16'b1001000);
    step(); PCSrcD = 0; PCSrcE = 1; settle();
    check("pc_e", ctl(), 16'b1001000);
    step(); PCSrcE = 0; PCSrcM = 1; settle();
    check("pc_m", ctl(), 16'b1001000);
    step(); PCSrcM = 0; PCSrcW = 1; settle();
    check("pc_w", ctl(), 16'b0001000);
    step(); PCSrcW = 0; settle();
    check("pc_done", ctl(), 16'h0000);
    check("pc_cnt", 16'(StallCount), 16'd10);

    // Reset in the middle of MULT
    MulOpE = 1;
    step();
    settle();
    check("rst_pre_busy", 16'(MulBusy), 16'd1);
    reset = 1;
    step();
    reset = 0;
    MulOpE = 0;
    settle();
    check("rst_mid_busy", 16'(MulBusy), 16'd0);
    check("rst_mid_cnt", 16'(StallCount), 16'd0);

    // Counter saturation with StallF held for 20 cycles
    PCSrcD = 1;
    for (int i = 0; i < 10; i++) step();
    settle();
    check("sat_mid", 16'(StallCount), 16'd10);
    for (int i = 0; i < 10; i++) step();
    PCSrcD = 0;
    settle();
    check("sat_cnt", 16'(StallCount), 16'd15);
    step();
    settle();
    check("sat_hold", 16'(StallCount), 16'd15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
